// File: rtl/nios_system_mem_checker_if.sv
// Avalon-MM bus between the memory checker (master) and the single-port
// on-chip memory (slave).
interface nios_system_mem_checker_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] m_address;
  logic [BE_W-1:0]   m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;

  modport master (
    output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
    output m_readdata
  );
endinterface

// File: rtl/nios_system_mem_checker.sv
// Hardware memory self-test master: writes a pattern over a word range, reads
// it back pipelined and counts mismatches. Define MEM_CHECKER_LFSR_EN for an LFSR pattern.
module nios_system_mem_checker #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ERR_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base,
  input  logic [ADDR_W:0]       length,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  nios_system_mem_checker_if.master m
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

`ifdef MEM_CHECKER_LFSR_EN
  localparam logic [DATA_W-1:0] LFSR_POLY = DATA_W'(32'h8020_0003);
`endif

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] pat_q;
  logic              cs_q;
  logic              wr_q;

  logic [READ_LATENCY-1:0]             pipe_v;
  logic [READ_LATENCY-1:0][DATA_W-1:0] pipe_exp;
  logic [READ_LATENCY-1:0][ADDR_W-1:0] pipe_addr;

  logic last_access;
  logic drain_empty;
  logic rd_mismatch;

  function automatic logic [DATA_W-1:0] pat_first(input logic [DATA_W-1:0] s);
`ifdef MEM_CHECKER_LFSR_EN
    return (s == '0) ? DATA_W'(1) : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p);
`ifdef MEM_CHECKER_LFSR_EN
    return p[0] ? ((p >> 1) ^ LFSR_POLY) : (p >> 1);
`else
    return p + 1'b1;
`endif
  endfunction

  // DRAIN may leave as soon as only the exiting (last-stage) entry remains;
  // the DONE cycle that follows covers its compare before done is raised.
  always_comb begin
    last_access = (idx == len_q - 1'b1);
    drain_empty = 1'b1;
    for (int unsigned k = 0; k + 1 < READ_LATENCY; k++) begin
      if (pipe_v[k]) drain_empty = 1'b0;
    end
    rd_mismatch = pipe_v[READ_LATENCY-1] &&
                  (m.m_readdata != pipe_exp[READ_LATENCY-1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      len_q          <= '0;
      idx            <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      seed_q         <= '0;
      pat_q          <= '0;
      cs_q           <= 1'b0;
      wr_q           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      pipe_v         <= '0;
      pipe_exp       <= '0;
      pipe_addr      <= '0;
    end else if (abort) begin
      state  <= IDLE;
      cs_q   <= 1'b0;
      wr_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      pipe_v <= '0;
    end else begin
      done <= 1'b0;

      pipe_v[0]    <= (state == READ);
      pipe_exp[0]  <= pat_q;
      pipe_addr[0] <= addr_q;
      for (int unsigned k = 1; k < READ_LATENCY; k++) begin
        pipe_v[k]    <= pipe_v[k-1];
        pipe_exp[k]  <= pipe_exp[k-1];
        pipe_addr[k] <= pipe_addr[k-1];
      end

      if (rd_mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) first_err_addr <= pipe_addr[READ_LATENCY-1];
      end

      case (state)
        IDLE: begin
          if (start) begin
            base_q         <= base;
            len_q          <= length;
            seed_q         <= seed;
            err_count      <= '0;
            first_err_addr <= '0;
            idx            <= '0;
            addr_q         <= base;
            pat_q          <= pat_first(seed);
            busy           <= 1'b1;
            if (length == '0) begin
              state <= DONE;
            end else begin
              state <= WRITE;
              cs_q  <= 1'b1;
              wr_q  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (last_access) begin
            state  <= READ;
            idx    <= '0;
            addr_q <= base_q;
            pat_q  <= pat_first(seed_q);
            wr_q   <= 1'b0;
          end else begin
            idx    <= idx + 1'b1;
            addr_q <= addr_q + 1'b1;
            pat_q  <= pat_next(pat_q);
          end
        end
        READ: begin
          if (last_access) begin
            state <= DRAIN;
            cs_q  <= 1'b0;
          end else begin
            idx    <= idx + 1'b1;
            addr_q <= addr_q + 1'b1;
            pat_q  <= pat_next(pat_q);
          end
        end
        DRAIN: begin
          if (drain_empty) state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m.m_address    = addr_q;
  assign m.m_byteenable = {BE_W{cs_q}};
  assign m.m_chipselect = cs_q;
  assign m.m_write      = wr_q;
  assign m.m_writedata  = pat_q;
  assign m.m_clken      = busy;

endmodule

// File: tb/tb_nios_system_mem_checker.sv
// Directed bench for nios_system_mem_checker against a behavioural
// single-port memory with an optional stuck-at-1 fault on bit 0 of word 0x010.
module tb_nios_system_mem_checker;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RL     = 1;
  localparam int unsigned ERR_W  = 16;
`ifdef MEM_CHECKER_LFSR_EN
  localparam bit LFSR = 1'b1;
`else
  localparam bit LFSR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [ADDR_W:0]   length = '0;
  logic [DATA_W-1:0] seed = '0;
  logic              busy;
  logic              done;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;

  nios_system_mem_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  nios_system_mem_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base(base), .length(length), .seed(seed),
    .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr), .m(bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] rd_addr_q = '0;
  bit                fault_en = 1'b0;
  int                cs_cycles = 0;
  int                be_bad = 0;
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_data [$];

  always @(posedge clk) begin
    if (bus.m_clken && bus.m_chipselect) begin
      if (bus.m_write) begin
        mem[bus.m_address] <= bus.m_writedata;
        log_addr.push_back(bus.m_address);
        log_data.push_back(bus.m_writedata);
      end
      rd_addr_q <= bus.m_address;
    end
    if (bus.m_chipselect) begin
      cs_cycles++;
      if (bus.m_byteenable != 4'hF) be_bad++;
    end
  end

  assign bus.m_readdata = mem[rd_addr_q] |
                          DATA_W'(fault_en && (rd_addr_q == ADDR_W'(16)));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_test(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                          input logic [DATA_W-1:0] s, input bit poke,
                          output int busy_n, output bit done_seen,
                          output bit busy_at_done, output int done_w);
    @(negedge clk);
    base = b; length = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; done_seen = 1'b0; busy_at_done = 1'b0; done_w = 0;
    for (int c = 0; c < 6000 && !done_seen; c++) begin
      if (done) begin
        done_seen = 1'b1;
        busy_at_done = busy;
      end else begin
        if (busy) busy_n++;
        if (poke && c == 2) begin
          start = 1'b1;
          length = '0;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (done_seen) begin
      @(negedge clk);
      done_w = done ? 2 : 1;
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] seed;
    bit                fault;
    bit                poke;
    int                exp_busy;
    int                exp_err;
    logic [ADDR_W-1:0] exp_first;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int busy_n, done_w, rd_seen, cs_before;
    bit done_seen, busy_at_done, done_any;
    logic [ADDR_W-1:0] wrap_a [4];

    vecs[0] = '{11'd0,    12'd2048, 32'h1000_0000, 1'b0, 1'b0, 4098, 0, 11'h000};
    vecs[1] = '{11'd2046, 12'd4,    32'hA5A5_0000, 1'b0, 1'b0, 10,   0, 11'h000};
    vecs[2] = '{11'd0,    12'd32,   32'h0000_0000, 1'b1, 1'b0, 66,   1, 11'h010};
    vecs[3] = '{11'd100,  12'd1,    32'h0000_0007, 1'b0, 1'b0, 4,    0, 11'h000};
    vecs[4] = '{11'd200,  12'd8,    32'h0000_0055, 1'b0, 1'b1, 18,   0, 11'h000};
    vecs[5] = '{11'd8,    12'd16,   32'h0000_0011, 1'b1, 1'b0, 34,   0, 11'h000};
    vecs[6] = '{11'h010,  12'd3,    32'h0000_0020, 1'b1, 1'b0, 8,    1, 11'h010};
    wrap_a  = '{11'd2046, 11'd2047, 11'd0, 11'd1};

    for (int unsigned a = 0; a < 2**ADDR_W; a++) mem[a] = '0;

    #2;
    check("reset_busy_done", {busy, done}, 2'b00);
    check("reset_err", {err_count, first_err_addr}, '0);
    check("reset_bus", {bus.m_chipselect, bus.m_write, bus.m_clken, bus.m_byteenable}, '0);
    check("reset_addr_wdata", {bus.m_address, bus.m_writedata}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      if (LFSR && vecs[v].fault) continue;
      fault_en = vecs[v].fault;
      log_addr.delete();
      log_data.delete();
      run_test(vecs[v].base, vecs[v].length, vecs[v].seed, vecs[v].poke,
               busy_n, done_seen, busy_at_done, done_w);
      check($sformatf("v%0d_done_seen", v), done_seen, 1'b1);
      check($sformatf("v%0d_busy_cycles", v), busy_n, vecs[v].exp_busy);
      check($sformatf("v%0d_busy_at_done", v), busy_at_done, 1'b0);
      check($sformatf("v%0d_done_width", v), done_w, 1);
      check($sformatf("v%0d_err_count", v), err_count, vecs[v].exp_err);
      if (vecs[v].exp_err != 0)
        check($sformatf("v%0d_first_err", v), first_err_addr, vecs[v].exp_first);
      check($sformatf("v%0d_write_count", v), log_addr.size(), vecs[v].length);
`ifndef MEM_CHECKER_LFSR_EN
      if (v == 0) check("fill_word5", mem[5], 32'h1000_0005);
      if (v == 1) begin
        for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
          check($sformatf("wrap_addr%0d", k), log_addr[k], wrap_a[k]);
          check($sformatf("wrap_data%0d", k), log_data[k], 32'hA5A5_0000 + 32'(k));
        end
      end
`endif
    end
    fault_en = 1'b0;

    // zero length: done two cycles after start, no bus activity, counters cleared
    cs_before = cs_cycles;
    @(negedge clk);
    base = 11'd5; length = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zl_cycle1", {busy, done}, 2'b10);
    @(negedge clk);
    check("zl_cycle2", {busy, done}, 2'b01);
    check("zl_no_cs", cs_cycles - cs_before, 0);
    check("zl_err", err_count, 0);

    // start and abort together: abort wins
    @(negedge clk);
    base = '0; length = 12'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {busy, bus.m_chipselect}, 2'b00);

    // abort during READ at i=10, after a mismatch at word 0x010 (i=8)
    fault_en = 1'b1;
    @(negedge clk);
    base = 11'd8; length = 12'd32; seed = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_seen = 0;
    for (int c = 0; c < 200 && rd_seen < 11; c++) begin
      if (bus.m_chipselect && !bus.m_write) rd_seen++;
      if (rd_seen < 11) @(negedge clk);
    end
    check("abort_reached_read10", rd_seen, 11);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_cs_wr_busy", {bus.m_chipselect, bus.m_write, busy}, 3'b000);
    done_any = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy || bus.m_chipselect) done_any = 1'b1;
    end
    check("abort_stays_idle", done_any, 1'b0);
`ifndef MEM_CHECKER_LFSR_EN
    check("abort_err_hold", {err_count, first_err_addr}, {16'd1, 11'h010});
`endif
    fault_en = 1'b0;

    // asynchronous reset mid-WRITE
    @(negedge clk);
    base = 11'd300; length = 12'd100; seed = 32'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_writing", {bus.m_chipselect, bus.m_write}, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_ctl", {busy, done, bus.m_chipselect, bus.m_write, bus.m_clken, bus.m_byteenable}, '0);
    check("async_rst_data", {bus.m_address, bus.m_writedata, err_count, first_err_addr}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    done_any = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || busy) done_any = 1'b1;
    end
    check("post_reset_idle", done_any, 1'b0);

`ifdef MEM_CHECKER_LFSR_EN
    log_addr.delete();
    log_data.delete();
    run_test(11'd0, 12'd4, 32'h0, 1'b0, busy_n, done_seen, busy_at_done, done_w);
    check("lfsr_done", done_seen, 1'b1);
    check("lfsr_word0", log_data.size() > 0 ? log_data[0] : 32'hDEAD, 32'h0000_0001);
    check("lfsr_word1", log_data.size() > 1 ? log_data[1] : 32'hDEAD, 32'h8020_0003);
    check("lfsr_err", err_count, 0);
`endif

    check("byteenable_all_ones", be_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nios_system_mem_checker.md
Name: nios_system_mem_checker

Overview:
- Avalon-MM initiator that drives the single-port on-chip memory slave (11-bit word address, 32-bit data, byteenable, chipselect/write, combinational readdata one clock after address).
- On start: writes a generated pattern over a word range, reads the range back pipelined, and compares.
- Reports done, error count and first failing address.
- Sits beside the Nios core as a hardware memory self-test and bring-up master.

Parameters:
- ADDR_W, 11, word-address width of the target memory.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, clocks from read-address cycle to valid readdata, 1..4.
- ERR_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; launches a test when idle.
- abort  in  1  synchronous; returns to IDLE at the next edge, no further accesses.
- base  in  ADDR_W  first word address, sampled on start.
- length  in  ADDR_W+1  word count, 0..2^ADDR_W, sampled on start.
- seed  in  DATA_W  pattern seed, sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at test completion.
- err_count  out  ERR_W  mismatches in the last test, saturating.
- first_err_addr  out  ADDR_W  address of the first mismatch; valid when err_count != 0.
- m_address  out  ADDR_W  memory address.
- m_byteenable  out  DATA_W/8  all ones while chipselect is high, else 0.
- m_chipselect  out  1  access strobe.
- m_write  out  1  write qualifier.
- m_writedata  out  DATA_W  write data.
- m_clken  out  1  memory clock enable; tied high except low in IDLE.
- m_readdata  in  DATA_W  memory read data.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, compare pipeline cleared. Reset mid-test abandons the test with no done pulse.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE, start=1:
  - Latch base, length and seed. Clear err_count and first_err_addr. Index i=0.
  - If length==0, go to DONE directly with no memory access.
  - Otherwise go to WRITE.
- start while busy is ignored.
- WRITE:
  - One write per clock: m_chipselect=1, m_write=1, m_address=(base+i) mod 2^ADDR_W (wraps), m_writedata=P(i).
  - After write length-1, reset i and go to READ.
- READ:
  - One read per clock: m_chipselect=1, m_write=0, same address rule.
  - A READ_LATENCY-deep pipeline carries valid, expected P(i) and address.
  - After the last read, go to DRAIN.
- DRAIN: wait until the pipeline is empty, then go to DONE.
- Compare: when a pipeline entry exits valid, compare m_readdata to expected.
  - On mismatch, err_count increments and saturates at all ones.
  - first_err_addr is written only on the first mismatch.
  - Compares complete during READ/DRAIN, so the last word is checked before done.
- DONE: done=1 for one clock, busy=0, then IDLE. err_count and first_err_addr hold until the next start.
- Pattern P(i) = seed + i, modulo 2^DATA_W.
- Timing: total busy cycles = 2*length + READ_LATENCY + 1 for length>0.
- abort: in any state, clear chipselect and write at the next edge, flush the pipeline, go to IDLE. No done pulse; counters hold.
- start and abort in the same cycle: abort wins.

Optional Feature:
- Macro MEM_CHECKER_LFSR_EN.
- Defined: P(0)=seed; if seed==0, P(0)=1. P(i+1) = 32-bit Galois LFSR step of P(i), polynomial 0x80200003. The read phase regenerates the same sequence from the latched seed.
- Undefined: incrementing pattern as in Behaviour; no LFSR logic synthesised.

Test Plan:
- Fill and check: base=0, length=2048, seed=0x1000_0000, behavioural memory model → done after 4098 cycles, err_count=0, word 5 reads 0x1000_0005.
- Wrap: base=2046, length=4 → writes to addresses 2046, 2047, 0, 1 with seed..seed+3; err_count=0.
- Fault: memory model forces bit 0 of address 0x010 stuck at 1, seed=0, base=0, length=32 → err_count=1, first_err_addr=0x010.
- Zero length: length=0 → done in the second cycle after start, no chipselect ever high, err_count=0.
- Abort plus reset: abort during READ at i=10 → chipselect low at the next clock, no done, state IDLE. Then assert reset_n=0 mid-WRITE → all outputs 0 asynchronously.
- LFSR (macro defined): seed=0 → first written word 0x0000_0001, second word 0x8020_0003; readback err_count=0.
